fetch_redirect_ctrl: RTL and testbench
======================================

# fetch_redirect_ctrl

Next-PC sequencer for the dual-issue fetch stage. Every cycle it chooses the address of the next two-instruction fetch pair from these sources: sequential advance, exception vector, ERET return, and branch/jump targets resolved in ID. It tracks branch-delay-slot placement across fetch pairs and waits for late `jr` targets. It drives the lane-kill and IF/ID flush controls, and replaces the level-sensitive request latches in the fetch front end with one registered FSM.

## Interface
Parameters:
- `RESET_PC`, default `32'hBFC0_0000`: fetch address after reset.
- `EXC_VECTOR`, default `32'hBFC0_0380`: exception/interrupt entry.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `stall`  in  1  backend hold; freezes `pc`, state and pending fields.
- `inst_valid`  in  1  pair at `pc` is returned this cycle.
- `exc_req`  in  1  exception/interrupt taken (one-cycle pulse).
- `eret_req`  in  1  ERET committed (pulse).
- `cp0_epc`  in  32  ERET return address.
- `br_valid`  in  1  taken branch/jump decided in ID (pulse, ignored while `stall`).
- `br_lane`  in  1  lane of the branch in its pair (0/1).
- `br_target`  in  32  target; for `jr` it is forwarded and may be late.
- `br_target_ok`  in  1  `br_target` is valid this cycle.
- `pc`  out  32  fetch address of the current pair (lane 0 = `pc`, lane 1 = `pc+4`).
- `kill_lane1`  out  1  comb: load lane 1 of this cycle's pair into ID as a bubble.
- `flush_if`  out  1  comb: load both lanes of this cycle's pair into ID as bubbles.
- `redirect`  out  1  comb: `pc` changes to a non-sequential address at the next edge.
- `fetch_adel`  out  1  comb: `pc[1:0] != 0` (fetch address error).

## Operation
- State enum: `RUN`, `SLOT`, `JRWAIT`. Pending registers: `pend_lane1`, `pend_ok`.
- Priority per cycle: `exc_req` > `eret_req` > state action / `br_valid` > sequential.
- `exc_req`: the next `pc` is `EXC_VECTOR`, `flush_if`=1, state goes to `RUN`, and pending fields clear. This applies from any state and is applied even when `stall`=1.
- `eret_req` with no `exc_req`: the next `pc` is `cp0_epc`. Otherwise it behaves the same as `exc_req`, including overriding `stall`.
- `RUN` with `br_valid`:
  - Lane 0: the delay slot is lane 1 of the branch pair, which is already in ID, so the current pair is wrong-path and `flush_if`=1.
    - If `br_target_ok`: the next `pc` is `br_target` and state stays `RUN`.
    - Otherwise: state goes to `JRWAIT` and `pc` is held.
  - Lane 1: the delay slot is lane 0 of the current pair.
    - If `inst_valid`: `kill_lane1`=1. If `br_target_ok`, the next `pc` is `br_target`; otherwise go to `JRWAIT`.
    - If `inst_valid`=0: go to `SLOT` and latch `pend_ok`. `br_target` is captured into an internal target register whenever `br_target_ok`.
- `SLOT`: `pc` is held until `inst_valid`. When it arrives, `kill_lane1`=1.
  - If a target is captured or `br_target_ok` is high, the next `pc` is that target and state goes to `RUN`.
  - Otherwise state goes to `JRWAIT`.
- `JRWAIT`: `pc` is held, and `flush_if`=1 whenever `inst_valid`. When `br_target_ok`, the next `pc` is `br_target`, `redirect`=1, and state goes to `RUN`. The ID source keeps driving/forwarding `br_target` until ok; `br_valid` is not re-asserted.
- `RUN` with no event: if `inst_valid` and not `stall`, `pc` advances to `pc+8`; otherwise it is held.
- Address arithmetic is 32-bit modulo: `0xFFFF_FFF8+8` wraps to 0. `fetch_adel` is pure decode; this block does not act on it.

## Timing
- Reset values: `pc`=`RESET_PC`, state `RUN`, pending fields 0. While `reset`=0 all comb outputs are 0 except `fetch_adel`, which decodes `RESET_PC`.
- `pc` is registered. A redirect decided in cycle t appears in `pc` at cycle t+1, giving one-cycle redirect latency. `kill_lane1` and `flush_if` qualify the pair presented in cycle t.
- `stall`=1 blocks every update except exc/eret. While stalled, `kill_lane1`, `flush_if` and `redirect` are 0 unless exc/eret is present.
- If `br_valid` and `exc_req` arrive in the same cycle, the branch is dropped.
- `reset` asserted mid-`JRWAIT` or mid-`SLOT` aborts the operation immediately and asynchronously.

## Structure
- A shared package `fetch_pkg` holds the state enum, `RESET_PC`/`EXC_VECTOR` defaults, and the pair stride `32'd8`.
- A single module is sufficient. An optional sub-module `next_pc_mux` holds the priority-encoded combinational target selection, with the FSM and registers kept in the top module.

## Test plan
- Reset release with `inst_valid`=1 each cycle → `pc` sequence `BFC00000`, `BFC00008`, `BFC00010`.
- At `pc`=`BFC00010`, `br_valid`, lane 0, target `BFC00100`, ok → `flush_if`=1 that cycle, next `pc`=`BFC00100`.
- Lane-1 branch, target `BFC00200` ok, `inst_valid`=0 for 2 cycles → state `SLOT` and `pc` held; on `inst_valid`, `kill_lane1`=1, then `pc`=`BFC00200`.
- Lane-0 `jr` with `br_target_ok` low 3 cycles → `JRWAIT`, `pc` held, `flush_if` on each `inst_valid`; on ok with `BFC00300`, next `pc`=`BFC00300`, state `RUN`.
- In `JRWAIT` with `stall`=1, `exc_req` → next `pc`=`BFC00380`, state `RUN`; a later `br_target_ok` is ignored.
- `eret_req` and `br_valid` in the same cycle, `cp0_epc`=`BFC00444` → next `pc`=`BFC00444`, branch discarded, `flush_if`=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage next-PC sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SLOT   = 2'd1,
        JRWAIT = 2'd2
    } fetch_state_e;

    typedef enum logic [2:0] {
        NPC_HOLD = 3'd0,
        NPC_SEQ  = 3'd1,
        NPC_EXC  = 3'd2,
        NPC_ERET = 3'd3,
        NPC_BR   = 3'd4,
        NPC_TGT  = 3'd5
    } npc_sel_e;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;
    localparam logic [31:0] PAIR_STRIDE        = 32'd8;

endpackage

// File: rtl/fetch_redirect_ctrl_next_pc_mux.sv
// Combinational next-PC source selection for the fetch sequencer.
module next_pc_mux
    import fetch_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  npc_sel_e    sel,
    input  logic [31:0] pc_q,
    input  logic [31:0] cp0_epc,
    input  logic [31:0] br_target,
    input  logic [31:0] tgt_q,
    output logic [31:0] pc_d
);

    always_comb begin
        pc_d = pc_q;
        unique case (sel)
            NPC_SEQ:  pc_d = pc_q + PAIR_STRIDE;
            NPC_EXC:  pc_d = EXC_VECTOR;
            NPC_ERET: pc_d = cp0_epc;
            NPC_BR:   pc_d = br_target;
            NPC_TGT:  pc_d = tgt_q;
            default:  pc_d = pc_q;
        endcase
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Next-PC sequencer for the dual-issue fetch stage: tracks delay-slot placement
// across fetch pairs, waits for late jr targets and drives lane-kill / IF flush.
module fetch_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        inst_valid,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] cp0_epc,
    input  logic        br_valid,
    input  logic        br_lane,
    input  logic [31:0] br_target,
    input  logic        br_target_ok,
    output logic [31:0] pc,
    output logic        kill_lane1,
    output logic        flush_if,
    output logic        redirect,
    output logic        fetch_adel
);

    fetch_state_e state_q, state_d;
    logic         pend_lane1_q, pend_lane1_d;
    logic         pend_ok_q, pend_ok_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    npc_sel_e     sel;
    logic         kill_c, flush_c, redirect_c;

    always_comb begin
        state_d      = state_q;
        pend_lane1_d = pend_lane1_q;
        pend_ok_d    = pend_ok_q;
        tgt_d        = tgt_q;
        sel          = NPC_HOLD;
        kill_c       = 1'b0;
        flush_c      = 1'b0;

        if (exc_req || eret_req) begin
            sel          = exc_req ? NPC_EXC : NPC_ERET;
            flush_c      = 1'b1;
            state_d      = RUN;
            pend_lane1_d = 1'b0;
            pend_ok_d    = 1'b0;
        end else if (!stall) begin
            unique case (state_q)
                RUN: begin
                    if (br_valid) begin
                        if (!br_lane) begin
                            // delay slot already in ID: whole current pair is wrong-path
                            flush_c = 1'b1;
                            if (br_target_ok) sel = NPC_BR;
                            else              state_d = JRWAIT;
                        end else if (inst_valid) begin
                            kill_c = 1'b1;
                            if (br_target_ok) sel = NPC_BR;
                            else              state_d = JRWAIT;
                        end else begin
                            state_d      = SLOT;
                            pend_lane1_d = 1'b1;
                            pend_ok_d    = br_target_ok;
                            if (br_target_ok) tgt_d = br_target;
                        end
                    end else if (inst_valid) begin
                        sel = NPC_SEQ;
                    end
                end
                SLOT: begin
                    if (br_target_ok && !pend_ok_q) begin
                        pend_ok_d = 1'b1;
                        tgt_d     = br_target;
                    end
                    if (inst_valid) begin
                        kill_c       = pend_lane1_q;
                        pend_lane1_d = 1'b0;
                        pend_ok_d    = 1'b0;
                        if (pend_ok_q) begin
                            sel     = NPC_TGT;
                            state_d = RUN;
                        end else if (br_target_ok) begin
                            sel     = NPC_BR;
                            state_d = RUN;
                        end else begin
                            state_d = JRWAIT;
                        end
                    end
                end
                JRWAIT: begin
                    flush_c = inst_valid;
                    if (br_target_ok) begin
                        sel     = NPC_BR;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        redirect_c = (sel != NPC_HOLD) && (sel != NPC_SEQ);
    end

    next_pc_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc_mux (
        .sel       (sel),
        .pc_q      (pc_q),
        .cp0_epc   (cp0_epc),
        .br_target (br_target),
        .tgt_q     (tgt_q),
        .pc_d      (pc_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            state_q      <= RUN;
            pend_lane1_q <= 1'b0;
            pend_ok_q    <= 1'b0;
            tgt_q        <= '0;
        end else begin
            pc_q         <= pc_d;
            state_q      <= state_d;
            pend_lane1_q <= pend_lane1_d;
            pend_ok_q    <= pend_ok_d;
            tgt_q        <= tgt_d;
        end
    end

    // Control outputs are forced quiet while reset is held.
    assign pc         = pc_q;
    assign kill_lane1 = reset & kill_c;
    assign flush_if   = reset & flush_c;
    assign redirect   = reset & redirect_c;
    assign fetch_adel = (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed plan steps, then
// randomized traffic against a flag-based behavioural model.
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] RPC = 32'hBFC0_0000;
    localparam logic [31:0] EXV = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, inst_valid = 1'b0, exc_req = 1'b0, eret_req = 1'b0;
    logic        br_valid = 1'b0, br_lane = 1'b0, br_target_ok = 1'b0;
    logic [31:0] cp0_epc = '0, br_target = '0;
    logic [31:0] pc;
    logic        kill_lane1, flush_if, redirect, fetch_adel;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: current pc, "delay slot still to arrive", "target unknown yet",
    // "target already known while waiting for slot".
    logic [31:0] m_pc, m_tgt;
    logic        m_slot, m_wait, m_have;

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(
        .RESET_PC   (RPC),
        .EXC_VECTOR (EXV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .inst_valid   (inst_valid),
        .exc_req      (exc_req),
        .eret_req     (eret_req),
        .cp0_epc      (cp0_epc),
        .br_valid     (br_valid),
        .br_lane      (br_lane),
        .br_target    (br_target),
        .br_target_ok (br_target_ok),
        .pc           (pc),
        .kill_lane1   (kill_lane1),
        .flush_if     (flush_if),
        .redirect     (redirect),
        .fetch_adel   (fetch_adel)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RPC; m_tgt = '0; m_slot = 1'b0; m_wait = 1'b0; m_have = 1'b0;
    endtask

    task automatic idle_inputs();
        stall = 0; inst_valid = 0; exc_req = 0; eret_req = 0;
        br_valid = 0; br_lane = 0; br_target_ok = 0;
    endtask

    // Called #1 after a rising edge with inputs already driven.
    task automatic step(input string tag);
        logic [31:0] n_pc, n_tgt;
        logic        n_slot, n_wait, n_have, k, f, r;
        n_pc = m_pc; n_tgt = m_tgt; n_slot = m_slot; n_wait = m_wait; n_have = m_have;
        k = 0; f = 0; r = 0;
        if (exc_req || eret_req) begin
            n_pc = exc_req ? EXV : cp0_epc;
            f = 1; r = 1; n_slot = 0; n_wait = 0; n_have = 0;
        end else if (!stall) begin
            if (m_wait) begin
                f = inst_valid;
                if (br_target_ok) begin n_pc = br_target; r = 1; n_wait = 0; end
            end else if (m_slot) begin
                if (br_target_ok && !m_have) begin n_have = 1; n_tgt = br_target; end
                if (inst_valid) begin
                    k = 1; n_slot = 0;
                    if (n_have) begin n_pc = n_tgt; r = 1; end
                    else n_wait = 1;
                    n_have = 0;
                end
            end else if (br_valid) begin
                if (!br_lane || inst_valid) begin
                    if (!br_lane) f = 1; else k = 1;
                    if (br_target_ok) begin n_pc = br_target; r = 1; end
                    else n_wait = 1;
                end else begin
                    n_slot = 1; n_have = br_target_ok;
                    if (br_target_ok) n_tgt = br_target;
                end
            end else if (inst_valid) begin
                n_pc = m_pc + 32'd8;
            end
        end
        #3;
        check({tag, ".kill"},  32'(kill_lane1), 32'(k));
        check({tag, ".flush"}, 32'(flush_if),   32'(f));
        check({tag, ".redir"}, 32'(redirect),   32'(r));
        @(posedge clk);
        #1;
        m_pc = n_pc; m_tgt = n_tgt; m_slot = n_slot; m_wait = n_wait; m_have = n_have;
        check({tag, ".pc"},   pc, m_pc);
        check({tag, ".adel"}, 32'(fetch_adel), 32'(m_pc[1:0] != 2'b00));
    endtask

    initial begin
        // Reset held: outputs quiet even with events on the inputs.
        #1 reset = 0;
        exc_req = 1; inst_valid = 1; br_valid = 1; br_target_ok = 1;
        #1;
        check("rst.pc", pc, RPC);
        check("rst.kill", 32'(kill_lane1), 32'd0);
        check("rst.flush", 32'(flush_if), 32'd0);
        check("rst.redir", 32'(redirect), 32'd0);
        check("rst.adel", 32'(fetch_adel), 32'd0);
        idle_inputs();
        @(posedge clk); #1;
        reset = 1;
        model_reset();

        // Sequential advance
        inst_valid = 1;
        step("seq0");
        step("seq1");
        check("seq.pc", pc, 32'hBFC0_0010);

        // Lane-0 branch with target ready
        br_valid = 1; br_lane = 0; br_target = 32'hBFC0_0100; br_target_ok = 1;
        step("br0");
        check("br0.pc", pc, 32'hBFC0_0100);

        // Lane-1 branch, delay-slot pair late by two cycles
        br_lane = 1; br_target = 32'hBFC0_0200; inst_valid = 0;
        step("br1.a");
        br_valid = 0; br_target_ok = 0;
        step("br1.b");
        step("br1.c");
        check("br1.hold", pc, 32'hBFC0_0100);
        inst_valid = 1;
        step("br1.d");
        check("br1.pc", pc, 32'hBFC0_0200);

        // Lane-0 jr with late target
        br_valid = 1; br_lane = 0; br_target_ok = 0;
        step("jr.a");
        br_valid = 0;
        step("jr.b");
        step("jr.c");
        step("jr.d");
        check("jr.hold", pc, 32'hBFC0_0200);
        br_target = 32'hBFC0_0300; br_target_ok = 1;
        step("jr.e");
        check("jr.pc", pc, 32'hBFC0_0300);
        br_target_ok = 0; inst_valid = 0;
        step("jr.f");

        // Exception during JRWAIT while stalled
        br_valid = 1; br_lane = 0;
        step("exc.a");
        br_valid = 0; stall = 1; exc_req = 1;
        step("exc.b");
        check("exc.pc", pc, EXV);
        stall = 0; exc_req = 0; br_target = 32'hBFC0_0500; br_target_ok = 1;
        step("exc.c");
        check("exc.ign", pc, EXV);
        br_target_ok = 0;

        // ERET beats a same-cycle branch
        eret_req = 1; cp0_epc = 32'hBFC0_0444;
        br_valid = 1; br_lane = 0; br_target = 32'hBFC0_0600; br_target_ok = 1;
        step("eret.a");
        check("eret.pc", pc, 32'hBFC0_0444);
        idle_inputs();
        step("eret.b");

        // Wrap-around and misaligned fetch decode
        eret_req = 1; cp0_epc = 32'hFFFF_FFF8;
        step("wrap.a");
        eret_req = 0; inst_valid = 1;
        step("wrap.b");
        check("wrap.pc", pc, 32'h0000_0000);
        eret_req = 1; cp0_epc = 32'h0000_0006; inst_valid = 0;
        step("adel");
        check("adel.bit", 32'(fetch_adel), 32'd1);
        eret_req = 0;

        // Async reset in the middle of SLOT
        br_valid = 1; br_lane = 1; br_target = 32'hBFC0_0700; br_target_ok = 1;
        step("rslot.a");
        idle_inputs();
        inst_valid = 1;
        #2 reset = 0;
        #1;
        check("rslot.pc", pc, RPC);
        check("rslot.kill", 32'(kill_lane1), 32'd0);
        @(posedge clk); #1;
        reset = 1;
        model_reset();
        step("rslot.b");
        check("rslot.seq", pc, RPC + 32'd8);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            stall        = ($urandom_range(7) == 0);
            exc_req      = ($urandom_range(40) == 0);
            eret_req     = ($urandom_range(40) == 0);
            cp0_epc      = ($urandom_range(9) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFF8);
            inst_valid   = ($urandom_range(3) != 0);
            br_valid     = ($urandom_range(4) == 0);
            br_lane      = 1'($urandom_range(1));
            br_target    = $urandom() & 32'hFFFF_FFFC;
            br_target_ok = ($urandom_range(2) == 0);
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
